// File: rtl/pck_injct_rx_checker_pkg.sv
// Shared types for the packet-injector receive checker: the FIFO record layout.
package pck_injct_rx_checker_pkg;

    localparam int unsigned REC_SRC_W  = 4;
    localparam int unsigned REC_SIZE_W = 5;

    typedef struct packed {
        logic [REC_SRC_W-1:0]  src;
        logic [REC_SIZE_W-1:0] size;
        logic [1:0]            err;   // {size_err, data_err}
    } rx_rec_t;

    function automatic rx_rec_t make_rec(logic [REC_SRC_W-1:0] src,
                                         logic [REC_SIZE_W-1:0] size,
                                         logic size_err, logic data_err);
        rx_rec_t r;
        r.src  = src;
        r.size = size;
        r.err  = {size_err, data_err};
        return r;
    endfunction

endpackage

// File: rtl/rx_rec_fifo.sv
// Synchronous record FIFO; head is shown combinationally from the storage array.
module rx_rec_fifo #(
    parameter int unsigned Width = 11,
    parameter int unsigned Depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [Width-1:0] wdata,
    input  logic             rd,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned Aw = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw:0]      wptr_q, rptr_q;
    logic             do_wr, do_rd;

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
        do_rd = rd && !empty;
        // A read at full frees the slot the concurrent write needs.
        do_wr = wr && (!full || rd);
        rdata = mem_q[rptr_q[Aw-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wptr_q[Aw-1:0]] <= wdata;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/pck_injct_rx_checker.sv
// Receive-side checker: compares delivered payloads to a per-source incrementing pattern,
// keeps statistics and queues one record per packet.
module pck_injct_rx_checker
    import pck_injct_rx_checker_pkg::*;
#(
    parameter int unsigned NE        = 16,
    parameter int unsigned NEw       = REC_SRC_W,
    parameter int unsigned Dw        = 128,
    parameter int unsigned PCK_SIZw  = REC_SIZE_W,
    parameter int unsigned MIN_SIZE  = 3,
    parameter int unsigned MAX_SIZE  = 20,
    parameter logic [Dw-1:0] PAT_BASE = 'h123456789ABCDEFEDCBA987654321,
    parameter int unsigned FIFO_D    = 8,
    parameter int unsigned CNTw      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pck_wr,
    input  logic [Dw-1:0]       pck_data,
    input  logic [PCK_SIZw-1:0] pck_size,
    input  logic [NEw-1:0]      pck_src_id,
    input  logic                rd_en,
    output logic                rd_valid,
    output logic [NEw-1:0]      rd_src,
    output logic [PCK_SIZw-1:0] rd_size,
    output logic [1:0]          rd_err,
    output logic [CNTw-1:0]     pck_cnt,
    output logic [CNTw-1:0]     err_cnt,
    output logic                ovf,
    input  logic [NEw-1:0]      exp_rd_id,
    output logic [CNTw-1:0]     exp_rd_seq
);
    localparam logic [PCK_SIZw-1:0] MinSz = PCK_SIZw'(MIN_SIZE);
    localparam logic [PCK_SIZw-1:0] MaxSz = PCK_SIZw'(MAX_SIZE);
    localparam logic [NEw:0]        NeLim = (NEw+1)'(NE);

    logic [CNTw-1:0] seq_q [NE];
    logic            src_ok, data_err, size_err, any_err;
    logic [Dw-1:0]   exp_data;
    rx_rec_t         wr_rec, rd_rec;
    logic            fifo_full, fifo_empty;

    always_comb begin
        src_ok   = ({1'b0, pck_src_id} < NeLim);
        exp_data = PAT_BASE + Dw'(seq_q[pck_src_id]);
        data_err = !src_ok || (pck_data != exp_data);
        size_err = !src_ok || (pck_size < MinSz) || (pck_size > MaxSz);
        any_err  = data_err || size_err;
        wr_rec   = make_rec(pck_src_id, pck_size, size_err, data_err);
    end

    rx_rec_fifo #(
        .Width ($bits(rx_rec_t)),
        .Depth (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (pck_wr),
        .wdata (wr_rec),
        .rd    (rd_en),
        .rdata (rd_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rd_valid   = !fifo_empty;
        rd_src     = rd_rec.src;
        rd_size    = rd_rec.size;
        rd_err     = rd_rec.err;
        exp_rd_seq = seq_q[exp_rd_id];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pck_cnt <= '0;
            err_cnt <= '0;
            ovf     <= 1'b0;
            for (int i = 0; i < NE; i++) seq_q[i] <= '0;
        end else if (pck_wr) begin
            // seq advances even on error so one bad packet does not cascade.
            if (src_ok) seq_q[pck_src_id] <= seq_q[pck_src_id] + CNTw'(1);
            if (pck_cnt != '1) pck_cnt <= pck_cnt + CNTw'(1);
            if (any_err && (err_cnt != '1)) err_cnt <= err_cnt + CNTw'(1);
            if (fifo_full && !rd_en) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pck_injct_rx_checker.sv
// Directed table-driven bench for pck_injct_rx_checker plus multi-cycle corner sequences.
module tb_pck_injct_rx_checker;

    localparam logic [127:0] PAT = 128'h123456789ABCDEFEDCBA987654321;

    typedef struct {
        logic [3:0] src;
        int         off;
        logic [4:0] size;
        logic [1:0] err;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pck_wr = 1'b0;
    logic [127:0] pck_data = '0;
    logic [4:0]   pck_size = '0;
    logic [3:0]   pck_src_id = '0;
    logic         rd_en = 1'b0;
    logic         rd_valid;
    logic [3:0]   rd_src;
    logic [4:0]   rd_size;
    logic [1:0]   rd_err;
    logic [31:0]  pck_cnt, err_cnt, exp_rd_seq;
    logic         ovf;
    logic [3:0]   exp_rd_id = '0;

    int n_chk = 0;
    int n_fail = 0;

    pck_injct_rx_checker dut (
        .clk        (clk),
        .reset      (reset),
        .pck_wr     (pck_wr),
        .pck_data   (pck_data),
        .pck_size   (pck_size),
        .pck_src_id (pck_src_id),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_src     (rd_src),
        .rd_size    (rd_size),
        .rd_err     (rd_err),
        .pck_cnt    (pck_cnt),
        .err_cnt    (err_cnt),
        .ovf        (ovf),
        .exp_rd_id  (exp_rd_id),
        .exp_rd_seq (exp_rd_seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] src, input int off, input logic [4:0] size);
        pck_src_id = src;
        pck_data   = PAT + 128'(off);
        pck_size   = size;
        pck_wr     = 1'b1;
    endtask

    task automatic send(input logic [3:0] src, input int off, input logic [4:0] size);
        drive(src, off, size);
        @(negedge clk);
        pck_wr = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [3:0] src,
                             input logic [4:0] size, input logic [1:0] err);
        check({name, ".valid"}, 64'(rd_valid), 64'd1);
        check({name, ".src"},   64'(rd_src),   64'(src));
        check({name, ".size"},  64'(rd_size),  64'(size));
        check({name, ".err"},   64'(rd_err),   64'(err));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic seq_check(input string name, input logic [3:0] id, input logic [31:0] exp);
        exp_rd_id = id;
        #1;
        check(name, 64'(exp_rd_seq), 64'(exp));
    endtask

    task automatic drain(output int cnt, output logic [4:0] last_size);
        cnt = 0;
        last_size = '0;
        while (rd_valid && cnt < 20) begin
            last_size = rd_size;
            rd_en = 1'b1;
            @(negedge clk);
            cnt++;
        end
        rd_en = 1'b0;
    endtask

    vec_t vecs[15];

    initial begin
        int        cnt;
        logic [4:0] last_sz;

        for (int k = 0; k < 10; k++) vecs[k] = '{4'd1, k, 5'(3 + k % 18), 2'b00};
        vecs[10] = '{4'd2, 0, 5'd4, 2'b00};
        vecs[11] = '{4'd2, 5, 5'd4, 2'b01};
        vecs[12] = '{4'd2, 2, 5'd4, 2'b00};
        vecs[13] = '{4'd4, 0, 5'd2, 2'b10};
        vecs[14] = '{4'd4, 1, 5'd21, 2'b10};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.rd_valid", 64'(rd_valid), 64'd0);
        check("rst.pck_cnt", 64'(pck_cnt), 64'd0);
        check("rst.err_cnt", 64'(err_cnt), 64'd0);
        check("rst.ovf", 64'(ovf), 64'd0);

        // Tests 1-3: one packet every two cycles, head popped in between.
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].src, vecs[i].off, vecs[i].size);
            pop_check($sformatf("vec%0d", i), vecs[i].src, vecs[i].size, vecs[i].err);
            if (i == 9) begin
                check("t1.pck_cnt", 64'(pck_cnt), 64'd10);
                check("t1.err_cnt", 64'(err_cnt), 64'd0);
                seq_check("t1.seq1", 4'd1, 32'd10);
            end
        end
        check("t3.pck_cnt", 64'(pck_cnt), 64'd15);
        check("t3.err_cnt", 64'(err_cnt), 64'd3);
        check("t3.empty", 64'(rd_valid), 64'd0);
        seq_check("t3.seq2", 4'd2, 32'd3);
        seq_check("t3.seq4", 4'd4, 32'd2);
        check("t3.ovf", 64'(ovf), 64'd0);

        // Test 4a: nine back-to-back packets overflow an 8-deep FIFO.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(4'd5, k, 5'd4);
            @(negedge clk);
        end
        pck_wr = 1'b0;
        check("t4.ovf", 64'(ovf), 64'd1);
        check("t4.pck_cnt", 64'(pck_cnt), 64'd9);
        check("t4.err_cnt", 64'(err_cnt), 64'd0);
        drain(cnt, last_sz);
        check("t4.held", 64'(cnt), 64'd8);

        // Test 4b: write and read together at full.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'd5, k, 5'd4);
            @(negedge clk);
        end
        drive(4'd5, 8, 5'd9);
        rd_en = 1'b1;
        @(negedge clk);
        pck_wr = 1'b0;
        rd_en  = 1'b0;
        check("t4b.ovf", 64'(ovf), 64'd0);
        check("t4b.err_cnt", 64'(err_cnt), 64'd0);
        drain(cnt, last_sz);
        check("t4b.occupancy", 64'(cnt), 64'd8);
        check("t4b.last_size", 64'(last_sz), 64'd9);

        // Test 5: same source on consecutive cycles.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'd3, k, 5'd5);
            @(negedge clk);
        end
        pck_wr = 1'b0;
        for (int k = 0; k < 3; k++) pop_check($sformatf("t5.%0d", k), 4'd3, 5'd5, 2'b00);
        seq_check("t5.seq3", 4'd3, 32'd3);

        // Empty FIFO with write and read together: record still lands.
        drive(4'd7, 0, 5'd6);
        rd_en = 1'b1;
        @(negedge clk);
        pck_wr = 1'b0;
        rd_en  = 1'b0;
        pop_check("t5.wr_rd_empty", 4'd7, 5'd6, 2'b00);

        // Test 6: reset with a record pending and a strobe in flight.
        do_reset();
        send(4'd6, 0, 5'd5);
        check("t6.pre_valid", 64'(rd_valid), 64'd1);
        drive(4'd6, 1, 5'd5);
        #2 reset = 1'b1;
        @(negedge clk);
        pck_wr = 1'b0;
        reset  = 1'b0;
        check("t6.rd_valid", 64'(rd_valid), 64'd0);
        check("t6.pck_cnt", 64'(pck_cnt), 64'd0);
        check("t6.err_cnt", 64'(err_cnt), 64'd0);
        check("t6.ovf", 64'(ovf), 64'd0);
        check("t6.rd_fields", 64'({rd_src, rd_size, rd_err}), 64'd0);
        seq_check("t6.seq6", 4'd6, 32'd0);
        @(negedge clk);
        send(4'd6, 0, 5'd5);
        pop_check("t6.post", 4'd6, 5'd5, 2'b00);
        check("t6.post_cnt", 64'(pck_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
